// File: rtl/adder_pkg.sv
// Shared types for the add/sub result capture path.
// Result word layout is {mode, flags, sum}.
package adder_pkg;

  localparam int FLAG_W = 4;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } adder_flags_t;

  typedef struct packed {
    logic         mode;
    adder_flags_t flags;
    logic [7:0]   sum;
  } adder_result_t;

endpackage

// File: rtl/adder_flag_gen.sv
// Combinational Z/N/C/V derivation for one 8-bit add/sub result.
// Overflow uses operand and result sign bits only.
module adder_flag_gen
  import adder_pkg::*;
(
  input  logic [7:0]   sum,
  input  logic         carry,
  input  logic         mode,
  input  logic         a_msb,
  input  logic         b_msb,
  output adder_flags_t flags
);

  logic sign_flip;

  assign sign_flip = (sum[7] != a_msb);

  always_comb begin
    flags   = '0;
    flags.z = (sum == 8'h00);
    flags.n = sum[7];
    flags.c = carry;
    // Subtract overflows only when operand signs differ.
    if (mode)
      flags.v = (a_msb != b_msb) && sign_flip;
    else
      flags.v = (a_msb == b_msb) && sign_flip;
  end

endmodule

// File: rtl/adder_result_fifo.sv
// Capture FIFO for add/sub results, FWFT valid/ready drain.
// ADDER_STATS_EN adds saturating add/sub/overflow counters.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_sum,
  input  logic                     in_carry,
  input  logic                     in_mode,
  input  logic                     in_a_msb,
  input  logic                     in_b_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_sum,
  output logic [FLAG_W-1:0]        out_flags,
  output logic                     out_mode,
  output logic [$clog2(DEPTH):0]   count
`ifdef ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0]         add_cnt,
  output logic [CNT_W-1:0]         sub_cnt,
  output logic [CNT_W-1:0]         ovf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  adder_result_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  adder_flags_t     flags;
  adder_result_t    wr_data;
  adder_result_t    head;
  logic             wr_en;
  logic             rd_en;

  adder_flag_gen u_flag_gen (
    .sum   (in_sum),
    .carry (in_carry),
    .mode  (in_mode),
    .a_msb (in_a_msb),
    .b_msb (in_b_msb),
    .flags (flags)
  );

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  always_comb begin
    wr_data       = '0;
    wr_data.mode  = in_mode;
    wr_data.flags = flags;
    wr_data.sum   = in_sum;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is masked so an empty FIFO never shows stale memory.
  always_comb begin
    head = '0;
    if (out_valid)
      head = mem[rd_ptr];
  end

  assign out_sum   = head.sum;
  assign out_flags = head.flags;
  assign out_mode  = head.mode;

`ifdef ADDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_cnt <= '0;
      sub_cnt <= '0;
      ovf_cnt <= '0;
    end else if (wr_en) begin
      if (!in_mode && (add_cnt != '1))
        add_cnt <= add_cnt + 1'b1;
      if (in_mode && (sub_cnt != '1))
        sub_cnt <= sub_cnt + 1'b1;
      if (flags.v && (ovf_cnt != '1))
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Randomized scoreboard bench for adder_result_fifo.
// Reference model works on plain integer add/sub arithmetic.
module tb_adder_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_sum = '0;
  logic in_carry = 1'b0;
  logic in_mode = 1'b0;
  logic in_a_msb = 1'b0;
  logic in_b_msb = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_sum;
  logic [3:0] out_flags;
  logic out_mode;
  logic [$clog2(DEPTH):0] count;
`ifdef ADDER_STATS_EN
  logic [CNT_W-1:0] add_cnt;
  logic [CNT_W-1:0] sub_cnt;
  logic [CNT_W-1:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [12:0] cur_exp = '0;
  logic [12:0] sb [$];
  int n_add = 0;
  int n_sub = 0;
  int n_ovf = 0;
  bit rand_done = 0;

  adder_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_mode   (in_mode),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .out_mode  (out_mode),
    .count     (count)
`ifdef ADDER_STATS_EN
    ,
    .add_cnt   (add_cnt),
    .sub_cnt   (sub_cnt),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected {mode, Z, N, C, V, sum} from integer arithmetic.
  function automatic logic [12:0] model(input int a, input int b,
                                        input bit m);
    int r;
    int sa;
    int sb2;
    int sr;
    logic [7:0] s;
    bit c;
    bit v;
    r   = m ? a - b : a + b;
    s   = r[7:0];
    c   = m ? (a < b) : (r > 255);
    sa  = (a > 127) ? a - 256 : a;
    sb2 = (b > 127) ? b - 256 : b;
    sr  = m ? sa - sb2 : sa + sb2;
    v   = (sr > 127) || (sr < -128);
    return {m, (s == 8'h00), s[7], c, v, s};
  endfunction

  task automatic drive(input int a, input int b, input bit m);
    int r;
    bit acc;
    r        = m ? a - b : a + b;
    cur_exp  = model(a, b, m);
    in_sum   = r[7:0];
    in_carry = m ? (a < b) : (r > 255);
    in_mode  = m;
    in_a_msb = (a > 127);
    in_b_msb = (b > 127);
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc)
      check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: checks head/occupancy each cycle, pops on read,
  // pushes the expected word on each accepted write.
  always @(negedge clk) begin
    int pre;
    if (!rst_n) begin
      sb.delete();
      n_add = 0;
      n_sub = 0;
      n_ovf = 0;
    end else begin
      pre = sb.size();
      check("count", 32'(count), pre);
      check("in_ready", 32'(in_ready), 32'(pre < DEPTH));
      check("out_valid", 32'(out_valid), 32'(pre != 0));
      if (pre != 0) begin
        check("head", {out_mode, out_flags, out_sum}, sb[0]);
        if (out_ready)
          void'(sb.pop_front());
      end else begin
        check("idle_zero", {out_mode, out_flags, out_sum}, 0);
      end
      if (in_valid && pre < DEPTH) begin
        sb.push_back(cur_exp);
        if (cur_exp[12]) n_sub++;
        else n_add++;
        if (cur_exp[8]) n_ovf++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;

    drive(8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_sum", 32'(out_sum), 32'h80);
    check("t1_flags", 32'(out_flags), 32'b0101);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;

    drive(8'h05, 8'h05, 1'b1);
    @(negedge clk);
    check("t2a_flags", 32'(out_flags), 32'b1000);
    @(posedge clk);
    #1;
    drive(8'h03, 8'h05, 1'b1);
    @(negedge clk);
    check("t2b_count", 32'(count), 2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    @(negedge clk);
    check("t2b_sum", 32'(out_sum), 32'hFE);
    check("t2b_flags", 32'(out_flags), 32'b0110);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      drive($urandom_range(0, 255), $urandom_range(0, 255),
            1'($urandom_range(0, 1)));
    @(negedge clk);
    check("t3_full_count", 32'(count), DEPTH);
    check("t3_full_ready", 32'(in_ready), 0);
    fork
      drive(8'h40, 8'h40, 1'b0);
      begin
        repeat (2) @(negedge clk);
        check("t3_held_count", 32'(count), DEPTH);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
      end
    join

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      drive($urandom_range(0, 255), $urandom_range(0, 255),
            1'($urandom_range(0, 1)));
    cycles(DEPTH + 2);
    @(negedge clk);
    check("t4_drained", 32'(count), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    for (int i = 0; i < 3; i++)
      drive($urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
    @(negedge clk);
    check("t5_pre_count", 32'(count), 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_count", 32'(count), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_out_sum", 32'(out_sum), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    drive(8'h7F, 8'h01, 1'b0);
    drive(8'h10, 8'h20, 1'b0);
    drive(8'h01, 8'h01, 1'b0);
    drive(8'h30, 8'h10, 1'b1);
    drive(8'h10, 8'h30, 1'b1);
    cycles(2);
`ifdef ADDER_STATS_EN
    @(negedge clk);
    check("t6_add_cnt", 32'(add_cnt), 3);
    check("t6_sub_cnt", 32'(sub_cnt), 2);
    check("t6_ovf_cnt", 32'(ovf_cnt), 1);
    @(posedge clk);
    #1;
`endif

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          drive($urandom_range(0, 255), $urandom_range(0, 255),
                1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0)
            cycles($urandom_range(1, 3));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          cycles(1);
        end
      end
    join
    out_ready = 1'b1;
    cycles(DEPTH + 4);
    @(negedge clk);
    check("final_count", 32'(count), 0);
`ifdef ADDER_STATS_EN
    check("final_add_cnt", 32'(add_cnt), n_add);
    check("final_sub_cnt", 32'(sub_cnt), n_sub);
    check("final_ovf_cnt", 32'(ovf_cnt), n_ovf);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
